axis_pack: RTL and testbench
============================

# axis_pack

Packs a narrow AXI-Stream into a wide one. It collects P_RATIO consecutive input beats into one output word and flushes a partial word early on s_axis_tlast, marking valid lanes in tkeep. It sits directly downstream of the axis_pipe register slice and feeds wide datapath consumers (DMA/packet buffers). It sustains one input beat per clock when the output is not back-pressured.

## Interface
- P_DATA_WIDTH, 8: input beat width (bits); also the lane width.
- P_RATIO, 4: lanes per output word; legal values 2..16.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high with tvalid.
- s_axis_tdata  input  P_DATA_WIDTH  input beat.
- s_axis_tlast  input  1  last beat of frame; forces flush.
- m_axis_tvalid  output  1  packed word valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tdata  output  P_DATA_WIDTH*P_RATIO  packed word; lane k = bits [k*P_DATA_WIDTH +: P_DATA_WIDTH].
- m_axis_tkeep  output  P_RATIO  lane k holds valid data.
- m_axis_tlast  output  1  word ends a frame.
- m_axis_word_count  output  32  words emitted (present only with AXIS_PACK_COUNT_EN).

## Operation
- State: assembly register acc (P_RATIO lanes), lane index idx (0..P_RATIO-1), output register (tdata/tkeep/tlast/tvalid).
- Input accept = s_axis_tvalid && s_axis_tready.
- s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready). This is combinational and lets a completing word overwrite the output register in the same cycle it drains.
- Each accepted beat is written into lane idx. Lane 0 is the first beat in time (little-endian lane order).
- Accepted beat with idx < P_RATIO-1 and tlast=0: acc lane idx <= data; idx <= idx+1.
- Accepted beat with idx == P_RATIO-1 or tlast=1 (completion):
  - output tdata <= acc with lane idx replaced by the new data, and lanes above idx forced to 0.
  - tkeep <= bits 0..idx set.
  - tlast <= s_axis_tlast; m_axis_tvalid <= 1.
  - idx <= 0; acc <= 0.
- Output drain: m_axis_tvalid && m_axis_tready with no completion in the same cycle gives m_axis_tvalid <= 0. tdata, tkeep and tlast hold their last values.
- Output register contents are stable while m_axis_tvalid && !m_axis_tready (AXI-S rule).
- tlast on a full word (idx == P_RATIO-1) gives a full tkeep with tlast=1. There is no extra empty word.
- A single-beat frame (tlast at idx 0) gives tkeep = 1 and lanes 1..P_RATIO-1 = 0.
- idx counts modulo P_RATIO; it never exceeds P_RATIO-1.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, idx=0, acc=0, word_count=0. s_axis_tready=0 while rst is high and 1 on the first cycle after.
- Reset mid-word discards any partial acc and any pending output word; nothing is flushed.
- Latency: m_axis_tvalid rises 1 cycle after the completing beat is accepted.
- Throughput: with m_axis_tready held at 1, one input beat is accepted every cycle with no bubbles. Output is 1 word per P_RATIO cycles, or earlier on tlast.
- Back-pressure: when m_axis_tvalid=1 and m_axis_tready=0, s_axis_tready=0. No beat is accepted, and idx and acc freeze.
- Simultaneous drain and completion in one cycle: the new word loads and m_axis_tvalid stays 1.

## Configuration
- AXIS_PACK_COUNT_EN defined: m_axis_word_count port exists. It increments by 1 on every output handshake (m_axis_tvalid && m_axis_tready), wraps 0xFFFFFFFF to 0, and resets to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use P_DATA_WIDTH=8, P_RATIO=4.
- Beats 0x11,0x22,0x33,0x44, tlast on 0x44, m_tready=1 -> one word 0x44332211, tkeep=0xF, tlast=1, 1 cycle after the 4th accept.
- Beats 0xA1,0xA2 with tlast on 0xA2 -> 0x0000A2A1, tkeep=0x3, tlast=1; the next frame starts at lane 0.
- 12 back-to-back beats 0x00..0x0B, m_tready=1 -> s_tready stays 1 every cycle; words 0x03020100, 0x07060504, 0x0B0A0908, tlast=0.
- First word complete with m_tready=0 for 5 cycles -> s_tready=0, output stable for all 5 cycles; when m_tready rises, the word drains and input resumes with no loss or duplication.
- rst pulsed after 2 beats of a word -> outputs return to reset values; the next 4 beats form a clean word with tkeep=0xF.
- With AXIS_PACK_COUNT_EN: 3 words drained -> m_axis_word_count=3; after rst -> 0.

Source files
------------

// File: rtl/axis_pack.sv
// Narrow-to-wide AXI-Stream packer: P_RATIO beats per word, early flush on tlast with tkeep lanes.
// Latency 1 cycle from completing beat to m_axis_tvalid; input stalls while a word is held unconsumed.
// Optional m_axis_word_count output handshake counter under AXIS_PACK_COUNT_EN.
module axis_pack #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_RATIO      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [P_DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [P_DATA_WIDTH*P_RATIO-1:0] m_axis_tdata,
    output logic [P_RATIO-1:0]              m_axis_tkeep,
    output logic                            m_axis_tlast
`ifdef AXIS_PACK_COUNT_EN
    ,
    output logic [31:0]                     m_axis_word_count
`endif
);

    localparam int IW = $clog2(P_RATIO);
    localparam logic [IW-1:0] LAST_IDX = IW'(P_RATIO - 1);

    typedef logic [P_RATIO-1:0][P_DATA_WIDTH-1:0] lanes_t;

    lanes_t               r_acc;
    lanes_t               r_tdata;
    logic [IW-1:0]        r_idx;
    logic [P_RATIO-1:0]   r_tkeep;
    logic                 r_tvalid;
    logic                 r_tlast;

    lanes_t               w_word;
    logic [P_RATIO-1:0]   w_keep;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_drain;

    // Ready looks through the output register so a draining word can be replaced in the same cycle.
    assign s_axis_tready = !rst && (!r_tvalid || m_axis_tready);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_complete    = w_accept && ((r_idx == LAST_IDX) || s_axis_tlast);
    assign w_drain       = r_tvalid && m_axis_tready;

    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int k = 0; k < P_RATIO; k++) begin
            if (k < int'(r_idx)) begin
                w_word[k] = r_acc[k];
                w_keep[k] = 1'b1;
            end else if (k == int'(r_idx)) begin
                w_word[k] = s_axis_tdata;
                w_keep[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_drain && !w_complete) begin
                r_tvalid <= 1'b0;
            end
            if (w_complete) begin
                r_tdata  <= w_word;
                r_tkeep  <= w_keep;
                r_tlast  <= s_axis_tlast;
                r_tvalid <= 1'b1;
                r_idx    <= '0;
                r_acc    <= '0;
            end else if (w_accept) begin
                r_acc[r_idx] <= s_axis_tdata;
                r_idx        <= r_idx + IW'(1);
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;

`ifdef AXIS_PACK_COUNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_count <= '0;
        end else if (w_drain) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign m_axis_word_count = r_word_count;
`endif

endmodule

// File: tb/tb_axis_pack.sv
// Randomized and directed bench for axis_pack (P_DATA_WIDTH=8, P_RATIO=4) against a queue-based frame model.
module tb_axis_pack;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
`ifdef AXIS_PACK_COUNT_EN
    logic [31:0] word_cnt;
`endif

    axis_pack #(.P_DATA_WIDTH(8), .P_RATIO(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .s_axis_tdata      (s_tdata),
        .s_axis_tlast      (s_tlast),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tlast      (m_tlast)
`ifdef AXIS_PACK_COUNT_EN
        ,
        .m_axis_word_count (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  lanes[$];
    word_t       exp_q[$];
    bit          acc_seen;
    bit          exp_rise;
    bit          stall_prev;
    word_t       stall_w;
    int          drained;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: frames are lists of beats; a word closes at four beats or at tlast.
    task automatic monitor();
        word_t w;
        acc_seen = 1'b0;
        if (rst) return;
        check("tready_rule", s_tready, !m_tvalid || m_tready);
        if (stall_prev) begin
            check("hold_vld", m_tvalid, 1);
            check("hold_dat", m_tdata, stall_w.d);
            check("hold_keep", m_tkeep, stall_w.k);
            check("hold_last", m_tlast, stall_w.l);
        end
        if (exp_rise) begin
            check("latency", m_tvalid, 1);
            exp_rise = 1'b0;
        end
        if (m_tvalid && m_tready) begin
            drained++;
            if (exp_q.size() == 0) begin
                check("spurious_word", m_tvalid, 0);
            end else begin
                w = exp_q.pop_front();
                check("word_dat", m_tdata, w.d);
                check("word_keep", m_tkeep, w.k);
                check("word_last", m_tlast, w.l);
            end
        end
        stall_prev = m_tvalid && !m_tready;
        stall_w.d  = m_tdata;
        stall_w.k  = m_tkeep;
        stall_w.l  = m_tlast;
        if (s_tvalid && s_tready) begin
            acc_seen = 1'b1;
            lanes.push_back(s_tdata);
            if (lanes.size() == 4 || s_tlast) begin
                w.d = '0;
                for (int k = 0; k < lanes.size(); k++) w.d = w.d | (32'(lanes[k]) << (8 * k));
                w.k = 4'((1 << lanes.size()) - 1);
                w.l = s_tlast;
                exp_q.push_back(w);
                lanes.delete();
                exp_rise = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, output int n);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_seen && n < 100);
        check("send_accepted", acc_seen, 1);
    endtask

    task automatic idle(input int cycles);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        step();
        lanes.delete();
        exp_q.delete();
        exp_rise   = 1'b0;
        stall_prev = 1'b0;
        drained    = 0;
        check("rst_tready", s_tready, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tlast", m_tlast, 0);
`ifdef AXIS_PACK_COUNT_EN
        check("rst_count", word_cnt, 0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_tready", s_tready, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        exp_rise = 1'b0; stall_prev = 1'b0; drained = 0; acc_seen = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Full frame of four beats
        m_tready = 1'b1;
        send(8'h11, 0, n); send(8'h22, 0, n); send(8'h33, 0, n); send(8'h44, 1, n);
        check("t1_vld", m_tvalid, 1);
        check("t1_dat", m_tdata, 32'h44332211);
        check("t1_keep", m_tkeep, 4'hF);
        check("t1_last", m_tlast, 1);
        idle(2);

        // Short frame, then the next frame restarts at lane 0
        send(8'hA1, 0, n); send(8'hA2, 1, n);
        check("t2_dat", m_tdata, 32'h0000A2A1);
        check("t2_keep", m_tkeep, 4'h3);
        check("t2_last", m_tlast, 1);
        send(8'hB1, 0, n); send(8'hB2, 0, n); send(8'hB3, 0, n); send(8'hB4, 0, n);
        check("t2_next_dat", m_tdata, 32'hB4B3B2B1);
        check("t2_next_keep", m_tkeep, 4'hF);
        check("t2_next_last", m_tlast, 0);

        // Single-beat frame
        send(8'h5A, 1, n);
        check("t2s_dat", m_tdata, 32'h0000005A);
        check("t2s_keep", m_tkeep, 4'h1);
        idle(2);

        // Twelve back-to-back beats, no bubbles
        for (int i = 0; i < 12; i++) begin
            send(8'(i), 0, n);
            check("t3_no_bubble", n, 1);
            if (i % 4 == 3) check("t3_dat", m_tdata, {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
        end
        idle(2);

        // Back-pressure for five cycles on a completed word
        m_tready = 1'b0;
        send(8'hC0, 0, n); send(8'hC1, 0, n); send(8'hC2, 0, n); send(8'hC3, 0, n);
        s_tvalid = 1'b1; s_tdata = 8'hD0; s_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_tready_low", s_tready, 0);
            check("t4_hold", m_tdata, 32'hC3C2C1C0);
            check("t4_vld", m_tvalid, 1);
            step();
        end
        m_tready = 1'b1;
        send(8'hD0, 0, n); send(8'hD1, 0, n); send(8'hD2, 0, n); send(8'hD3, 1, n);
        idle(3);
`ifdef AXIS_PACK_COUNT_EN
        check("count_total", word_cnt, drained);
`endif

        // Reset after two beats of a word discards them
        send(8'hE0, 0, n); send(8'hE1, 0, n);
        do_reset();
        m_tready = 1'b1;
        send(8'hF0, 0, n); send(8'hF1, 0, n); send(8'hF2, 0, n); send(8'hF3, 0, n);
        check("t5_dat", m_tdata, 32'hF3F2F1F0);
        check("t5_keep", m_tkeep, 4'hF);
        for (int i = 0; i < 8; i++) send(8'(8'h60 + i), 0, n);
        idle(3);
`ifdef AXIS_PACK_COUNT_EN
        check("count_three", word_cnt, 3);
`endif

        // Randomized traffic with random downstream stalls
        s_tvalid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!s_tvalid || acc_seen) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = 8'($urandom);
                s_tlast  = ($urandom_range(0, 4) == 0);
            end
            m_tready = ($urandom_range(0, 9) < 7);
            step();
        end
        s_tvalid = 1'b1; s_tdata = 8'h99; s_tlast = 1'b1;
        if (!acc_seen) begin
            send(8'h99, 1, n);
        end
        m_tready = 1'b1;
        send(8'h9A, 1, n);
        idle(5);
        check("queue_empty", exp_q.size(), 0);
`ifdef AXIS_PACK_COUNT_EN
        check("count_random", word_cnt, drained);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
